// File: rtl/dbg_pkg.sv
// Shared definitions for the debug RAM writer: FSM states, cursor encodings
// and default timing parameters.
package dbg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EDIT   = 2'd1,
      WRITE  = 2'd2,
      VERIFY = 2'd3
   } dbg_state_e;

   localparam logic [1:0] CUR_ADDR_HI = 2'd0;
   localparam logic [1:0] CUR_ADDR_LO = 2'd1;
   localparam logic [1:0] CUR_DATA_HI = 2'd2;
   localparam logic [1:0] CUR_DATA_LO = 2'd3;

   localparam int WR_HOLD_DEF = 4;
   localparam int RD_LAT_DEF  = 2;

   // Modulo-16 step of one nibble; never carries into its neighbour.
   function automatic logic [3:0] nib_step(input logic [3:0] n, input logic up);
      return up ? n + 4'd1 : n - 4'd1;
   endfunction

endpackage

// File: rtl/edge_pulse_detect.sv
// Registered rising-edge detector: one-cycle pulse per low-to-high transition.
module edge_pulse_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= 1'b0;
         rise <= 1'b0;
      end else begin
         prev <= level;
         rise <= level & ~prev;
      end
   end

endmodule

// File: rtl/dbg_ram_writer.sv
// Debug RAM writer: pulse/button editor for an address/data byte pair, a
// WR_HOLD-cycle write strobe and a readback compare with sticky error flag.
module dbg_ram_writer
   import dbg_pkg::*;
#(
   parameter int WR_HOLD = WR_HOLD_DEF,
   parameter int RD_LAT  = RD_LAT_DEF
) (
   input  logic       qzt_clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       pulse,
   input  logic       direction,
   input  logic       btn_next,
   input  logic       btn_write,
   input  logic [7:0] rd_data,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [7:0] rd_addr,
   output logic [1:0] cursor,
   output logic       busy,
   output logic       err,
   output logic [7:0] wr_count
);

   localparam logic [3:0] HOLD_LD = 4'(WR_HOLD);
   localparam logic [3:0] LAT_LD  = 4'(RD_LAT);

   dbg_state_e state;
   logic [3:0] cnt;
   logic       next_ev;
   logic       write_ev;
   logic [3:0] sel_nib;
   logic [3:0] new_nib;

   edge_pulse_detect u_next (
      .clk   (qzt_clk),
      .rst_n (reset_n),
      .level (btn_next),
      .rise  (next_ev)
   );

   edge_pulse_detect u_write (
      .clk   (qzt_clk),
      .rst_n (reset_n),
      .level (btn_write),
      .rise  (write_ev)
   );

   always_comb begin
      sel_nib = 4'h0;
      case (cursor)
         CUR_ADDR_HI: sel_nib = wr_addr[7:4];
         CUR_ADDR_LO: sel_nib = wr_addr[3:0];
         CUR_DATA_HI: sel_nib = wr_data[7:4];
         default:     sel_nib = wr_data[3:0];
      endcase
      new_nib = nib_step(sel_nib, direction);
   end

   always_ff @(posedge qzt_clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         wr_en    <= 1'b0;
         wr_addr  <= 8'h00;
         wr_data  <= 8'h00;
         rd_addr  <= 8'h00;
         cursor   <= CUR_ADDR_HI;
         busy     <= 1'b0;
         err      <= 1'b0;
         wr_count <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (enable) state <= EDIT;
            end

            // Priority: write > next > pulse; losers in the same cycle are dropped.
            EDIT: begin
               if (!enable) begin
                  state <= IDLE;
               end else if (write_ev) begin
                  state <= WRITE;
                  cnt   <= HOLD_LD;
                  wr_en <= 1'b1;
                  busy  <= 1'b1;
               end else if (next_ev) begin
                  cursor <= cursor + 2'd1;
               end else if (pulse) begin
                  case (cursor)
                     CUR_ADDR_HI: wr_addr[7:4] <= new_nib;
                     CUR_ADDR_LO: wr_addr[3:0] <= new_nib;
                     CUR_DATA_HI: wr_data[7:4] <= new_nib;
                     default:     wr_data[3:0] <= new_nib;
                  endcase
               end
            end

            WRITE: begin
               if (cnt == 4'd1) begin
                  state   <= VERIFY;
                  wr_en   <= 1'b0;
                  rd_addr <= wr_addr;
                  cnt     <= LAT_LD;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            // RD_LAT wait cycles plus the sampling cycle.
            default: begin
               if (cnt == 4'd0) begin
                  if (rd_data != wr_data) err <= 1'b1;
                  wr_count <= wr_count + 8'd1;
                  wr_addr  <= wr_addr + 8'd1;
                  cursor   <= CUR_DATA_HI;
                  busy     <= 1'b0;
                  state    <= enable ? EDIT : IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dbg_ram_writer.sv
// Directed plus randomized bench for dbg_ram_writer with a behavioural
// editor model and a RAM model with configurable read latency.
module tb_dbg_ram_writer;

   localparam int WR_HOLD = 4;
   localparam int RD_LAT  = 2;

   logic       qzt_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       pulse = 1'b0;
   logic       direction = 1'b0;
   logic       btn_next = 1'b0;
   logic       btn_write = 1'b0;
   logic [7:0] rd_data;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] rd_addr;
   logic [1:0] cursor;
   logic       busy;
   logic       err;
   logic [7:0] wr_count;

   int n_assert = 0;
   int n_fail = 0;
   int wr_en_total = 0;
   bit ram_bad = 1'b0;

   logic [7:0] m_addr, m_data, m_cnt;
   logic [1:0] m_cur;
   bit         m_err;

   logic [7:0] mem [256];
   logic [7:0] rd_pipe [RD_LAT];

   dbg_ram_writer #(.WR_HOLD(WR_HOLD), .RD_LAT(RD_LAT)) dut (
      .qzt_clk   (qzt_clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .pulse     (pulse),
      .direction (direction),
      .btn_next  (btn_next),
      .btn_write (btn_write),
      .rd_data   (rd_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr   (rd_addr),
      .cursor    (cursor),
      .busy      (busy),
      .err       (err),
      .wr_count  (wr_count)
   );

   always #10 qzt_clk = ~qzt_clk;

   // RAM: write on strobe, read data appears RD_LAT cycles after rd_addr.
   always @(posedge qzt_clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_pipe[0] <= ram_bad ? 8'h00 : mem[rd_addr];
      for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
      if (wr_en) wr_en_total <= wr_en_total + 1;
   end
   assign rd_data = rd_pipe[RD_LAT-1];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".wr_addr"},  wr_addr,  m_addr);
      chk({tag, ".wr_data"},  wr_data,  m_data);
      chk({tag, ".cursor"},   cursor,   m_cur);
      chk({tag, ".err"},      err,      m_err);
      chk({tag, ".wr_count"}, wr_count, m_cnt);
      chk({tag, ".busy"},     busy,     0);
      chk({tag, ".wr_en"},    wr_en,    0);
   endtask

   task automatic model_reset();
      m_addr = 0; m_data = 0; m_cnt = 0; m_cur = 0; m_err = 0;
   endtask

   // The editor as a 16-bit word of four nibbles, cursor 0 = most significant.
   task automatic m_pulse(input bit up);
      logic [15:0] w;
      int sh, n;
      w  = {m_addr, m_data};
      sh = (3 - int'(m_cur)) * 4;
      n  = int'((w >> sh) & 16'hF);
      n  = (n + (up ? 1 : 15)) % 16;
      w  = (w & ~(16'hF << sh)) | (16'(n) << sh);
      {m_addr, m_data} = w;
   endtask

   task automatic do_pulse(input bit up, input bit applies);
      pulse = 1'b1; direction = up;
      @(negedge qzt_clk);
      pulse = 1'b0;
      @(negedge qzt_clk);
      if (applies) m_pulse(up);
   endtask

   task automatic press_next();
      btn_next = 1'b1;
      repeat (2) @(negedge qzt_clk);
      btn_next = 1'b0;
      @(negedge qzt_clk);
      m_cur = m_cur + 2'd1;
   endtask

   task automatic goto_cursor(input logic [1:0] c);
      while (m_cur != c) press_next();
   endtask

   task automatic set_value(input logic [7:0] a, input logic [7:0] d);
      logic [15:0] tgt, cur;
      int diff;
      tgt = {a, d};
      for (int p = 0; p < 4; p++) begin
         goto_cursor(2'(p));
         cur  = {m_addr, m_data};
         diff = (int'((tgt >> ((3-p)*4)) & 16'hF) - int'((cur >> ((3-p)*4)) & 16'hF) + 16) % 16;
         if (diff <= 8) repeat (diff) do_pulse(1'b1, 1'b1);
         else           repeat (16 - diff) do_pulse(1'b0, 1'b1);
      end
   endtask

   task automatic do_write(input bit bad, input bit drop_en, input bit noisy);
      int wr_cyc, busy_cyc;
      bit stable;
      logic [7:0] a0;
      wr_cyc = 0; busy_cyc = 0; stable = 1'b1; a0 = m_addr;
      ram_bad   = bad;
      btn_write = 1'b1;
      if (noisy) btn_next = 1'b1;
      @(negedge qzt_clk);
      chk("wr_latency_1", wr_en, 0);
      // rotation pulse lands in the same FSM cycle as the registered button events
      if (noisy) begin pulse = 1'b1; direction = 1'b1; end
      @(negedge qzt_clk);
      pulse = 1'b0;
      chk("wr_latency_2", wr_en, 1);
      if (drop_en) enable = 1'b0;
      for (int t = 0; t < 64 && busy; t++) begin
         if (wr_en) begin
            wr_cyc++;
            if (wr_addr !== m_addr || wr_data !== m_data) stable = 1'b0;
         end
         busy_cyc++;
         if (noisy) begin pulse = ~pulse; direction = 1'($urandom_range(0, 1)); end
         @(negedge qzt_clk);
      end
      pulse = 1'b0;
      chk("wr_cycles", wr_cyc, WR_HOLD);
      chk("busy_cycles", busy_cyc, WR_HOLD + RD_LAT + 1);
      chk("wr_stable", stable, 1);
      chk("rd_addr", rd_addr, a0);
      m_cnt++;
      if (bad && m_data != 8'h00) m_err = 1'b1;
      m_addr++;
      m_cur = 2'd2;
      repeat (3) begin
         @(negedge qzt_clk);
         chk("no_retrigger", wr_en, 0);
      end
      btn_write = 1'b0; btn_next = 1'b0; ram_bad = 1'b0;
      @(negedge qzt_clk);
      check_state("post_write");
   endtask

   task automatic random_ops(input int n, input bit allow_bad);
      int r;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 5)      do_pulse(1'($urandom_range(0, 1)), 1'b1);
         else if (r <= 7) press_next();
         else             do_write(allow_bad && ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
         check_state("random");
      end
   endtask

   initial begin
      model_reset();
      #5;
      check_state("reset");
      chk("reset.rd_addr", rd_addr, 0);

      @(negedge qzt_clk);
      reset_n = 1'b1;
      enable  = 1'b1;
      @(negedge qzt_clk);

      // three increments on ADDR_HI, then move the cursor
      repeat (3) do_pulse(1'b1, 1'b1);
      press_next();
      chk("edit.addr30", wr_addr, 8'h30);
      chk("edit.cursor1", cursor, 2'd1);
      chk("edit.no_wr_en", wr_en_total, 0);

      // nibble wrap both ways, no carry into ADDR_HI
      do_pulse(1'b0, 1'b1);
      chk("wrap.0_minus_1", wr_addr, 8'h3F);
      do_pulse(1'b1, 1'b1);
      chk("wrap.F_plus_1", wr_addr, 8'h30);
      do_pulse(1'b0, 1'b1);
      chk("wrap.back_to_F", wr_addr, 8'h3F);
      check_state("wrap");

      // basic write with echoing RAM
      set_value(8'h10, 8'hA5);
      check_state("pre_write");
      do_write(1'b0, 1'b0, 1'b0);
      chk("w1.addr_inc", wr_addr, 8'h11);
      chk("w1.count", wr_count, 1);
      chk("w1.err", err, 0);
      chk("w1.cursor", cursor, 2'd2);

      // simultaneous write/next/pulse on DATA_LO, then pulse noise while busy
      goto_cursor(2'd3);
      do_write(1'b0, 1'b0, 1'b1);

      // enable drops during WRITE: strobe completes, then editor is idle
      do_write(1'b0, 1'b1, 1'b0);
      do_pulse(1'b1, 1'b0);
      check_state("idle_ignores_pulse");
      enable = 1'b1;
      repeat (2) @(negedge qzt_clk);
      do_pulse(1'b1, 1'b1);
      check_state("edit_after_idle");

      random_ops(30, 1'b0);

      // readback mismatch at 0xFF, then sticky through a good write
      set_value(8'hFF, 8'h5A);
      do_write(1'b1, 1'b0, 1'b0);
      chk("fault.err", err, 1);
      chk("fault.addr_wrap", wr_addr, 8'h00);
      do_write(1'b0, 1'b0, 1'b0);
      chk("fault.err_sticky", err, 1);

      // reset in the middle of the strobe
      btn_write = 1'b1;
      repeat (3) @(negedge qzt_clk);
      chk("midrst.wr_en_before", wr_en, 1);
      #2;
      reset_n   = 1'b0;
      btn_write = 1'b0;
      #1;
      model_reset();
      check_state("midrst");
      chk("midrst.rd_addr", rd_addr, 0);
      @(negedge qzt_clk);
      reset_n = 1'b1;
      repeat (3) @(negedge qzt_clk);
      check_state("after_rst");

      random_ops(30, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
